// File: rtl/reg_bank_sequencer.sv
// Programmable micro-sequencer: steps a {A, B, Z, cmd} table and drives register-bank / ALU control.
// Optional single-step mode under REG_BANK_SEQ_SINGLE_STEP_EN (adds step input and PAUSE state).
module reg_bank_sequencer #(
  parameter int unsigned AW    = 3,
  parameter int unsigned CMD_W = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PC_W-1:0]         last_idx,
  input  logic                    hold,
`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
  input  logic                    step,
`endif
  input  logic                    prog_we,
  input  logic [PC_W-1:0]         prog_addr,
  input  logic [3*AW+CMD_W-1:0]   prog_data,
  output logic [AW-1:0]           rd_addr_a,
  output logic [AW-1:0]           rd_addr_b,
  output logic [AW-1:0]           wr_addr,
  output logic [CMD_W-1:0]        alu_cmd,
  output logic                    wr_en,
  output logic                    busy,
  output logic                    done,
  output logic [PC_W-1:0]         pc
);

  localparam int unsigned ENTRY_W  = 3*AW + CMD_W;
  localparam int unsigned LAST_MAX = DEPTH - 1;

`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE, PAUSE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      last_q, last_d;
  logic [ENTRY_W-1:0]   ir_q, ir_d;
  logic [ENTRY_W-1:0]   prog_mem_q [DEPTH];
  logic                 mem_we_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        IDLE:  if (start) state_d = FETCH;
        FETCH: state_d = EXEC;
        EXEC:  state_d = WB;
`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
        WB:    state_d = (pc_q == last_q) ? DONE : PAUSE;
        PAUSE: if (step) state_d = FETCH;
`else
        WB:    state_d = (pc_q == last_q) ? DONE : FETCH;
`endif
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state_q)
      IDLE:    busy  = 1'b0;
      WB:      wr_en = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Table writes are accepted only while idle; the write lands before a same-cycle start fetches.
  always_comb begin
    pc_d     = pc_q;
    last_d   = last_q;
    ir_d     = ir_q;
    mem_we_d = prog_we && (state_q == IDLE) && (32'(prog_addr) < DEPTH);
    if (!hold) begin
      case (state_q)
        IDLE: if (start) begin
          pc_d   = '0;
          last_d = (32'(last_idx) > LAST_MAX) ? PC_W'(LAST_MAX) : last_idx;
        end
        FETCH: ir_d = prog_mem_q[pc_q];
        WB:    if (pc_q != last_q) pc_d = pc_q + PC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      last_q <= '0;
      ir_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) prog_mem_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      last_q <= last_d;
      ir_q   <= ir_d;
      if (mem_we_d) prog_mem_q[prog_addr] <= prog_data;
    end
  end

  assign {rd_addr_a, rd_addr_b, wr_addr, alu_cmd} = ir_q;
  assign pc = pc_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: directed and random runs against a per-cycle timeline model.
module tb_reg_bank_sequencer;
  localparam int unsigned AW = 3, CMD_W = 4, DEPTH = 8, PC_W = 3;
  localparam int unsigned EW = 3*AW + CMD_W;

  typedef struct packed {
    logic            wr;
    logic            dn;
    logic            bz;
    logic [EW-1:0]   ent;
    logic [PC_W-1:0] pc;
  } snap_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, prog_we = 1'b0;
  logic [PC_W-1:0] last_idx = '0, prog_addr = '0;
  logic [EW-1:0] prog_data = '0;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [CMD_W-1:0] alu_cmd;
  logic wr_en, busy, done;
  logic [PC_W-1:0] pc;
`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  reg_bank_sequencer #(.AW(AW), .CMD_W(CMD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .last_idx(last_idx), .hold(hold),
`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .alu_cmd(alu_cmd),
    .wr_en(wr_en), .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] last_out;
  logic [PC_W-1:0] model_pc;
  snap_t tl[$];

  function automatic snap_t mk(input logic w, input logic d, input logic b,
                               input logic [EW-1:0] e, input int unsigned p);
    snap_t s;
    s.wr = w; s.dn = d; s.bz = b; s.ent = e; s.pc = PC_W'(p);
    return s;
  endfunction

  task automatic check(input snap_t e, input string tag, input int c);
    logic [EW-1:0] obs;
    obs = {rd_addr_a, rd_addr_b, wr_addr, alu_cmd};
    checks += 5;
    assert (wr_en === e.wr) else begin errors++; $error("FAIL %s wr_en cyc %0d: got %b exp %b", tag, c, wr_en, e.wr); end
    assert (done === e.dn) else begin errors++; $error("FAIL %s done cyc %0d: got %b exp %b", tag, c, done, e.dn); end
    assert (busy === e.bz) else begin errors++; $error("FAIL %s busy cyc %0d: got %b exp %b", tag, c, busy, e.bz); end
    assert (obs === e.ent) else begin errors++; $error("FAIL %s outs cyc %0d: got %h exp %h", tag, c, obs, e.ent); end
    assert (pc === e.pc) else begin errors++; $error("FAIL %s pc cyc %0d: got %0d exp %0d", tag, c, pc, e.pc); end
  endtask

  // Expected timeline: each entry costs fetch/exec/writeback, then one done cycle, then idle.
  task automatic build(input int unsigned last);
    tl.delete();
    for (int unsigned k = 0; k <= last; k++) begin
      tl.push_back(mk(1'b0, 1'b0, 1'b1, last_out, k));
      last_out = mem[k];
      tl.push_back(mk(1'b0, 1'b0, 1'b1, last_out, k));
      tl.push_back(mk(1'b1, 1'b0, 1'b1, last_out, k));
`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
      if (k != last) tl.push_back(mk(1'b0, 1'b0, 1'b1, last_out, k + 1));
`endif
    end
    tl.push_back(mk(1'b0, 1'b1, 1'b1, last_out, last));
    for (int unsigned j = 0; j < 3; j++) tl.push_back(mk(1'b0, 1'b0, 1'b0, last_out, last));
    model_pc = PC_W'(last);
  endtask

  task automatic prog_write(input int unsigned a, input logic [EW-1:0] d);
    prog_we = 1'b1; prog_addr = PC_W'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mem[a] = d;
  endtask

  task automatic run(input string tag, input int unsigned last, input int unsigned hold_at,
                     input int unsigned hold_len, input bit pw, input int unsigned pw_addr,
                     input logic [EW-1:0] pw_data, input int unsigned poke_at);
    int c;
    if (pw) mem[pw_addr] = pw_data;
    build(last);
    for (int unsigned j = 0; j < hold_len; j++) tl.insert(hold_at, tl[hold_at-1]);
    start = 1'b1; last_idx = PC_W'(last);
    prog_we = pw; prog_addr = PC_W'(pw_addr); prog_data = pw_data;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    for (int i = 0; i < tl.size(); i++) begin
      c = i + 1;
      check(tl[i], tag, c);
      hold = (hold_len > 0) && (c >= int'(hold_at)) && (c < int'(hold_at + hold_len));
      if (poke_at != 0 && c == int'(poke_at)) begin
        start = 1'b1; prog_we = 1'b1;
        prog_addr = PC_W'($urandom); prog_data = EW'($urandom); last_idx = PC_W'($urandom);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(negedge clk);
    end
    hold = 1'b0; start = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    int unsigned last, ha, hl, n;
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
    last_out = '0; model_pc = '0;

    repeat (2) @(negedge clk);
    check(mk(1'b0, 1'b0, 1'b0, '0, 0), "reset", 0);
    rst = 1'b0;
    @(negedge clk);

    prog_write(0, {3'd2, 3'd3, 3'd1, 4'b0000});
    prog_write(1, {3'd5, 3'd1, 3'd4, 4'b0001});
    prog_write(2, {3'd1, 3'd2, 3'd2, 4'b1010});
    run("default", 2, 0, 0, 1'b0, 0, '0, 0);
    run("hold_wb", 2, 6, 4, 1'b0, 0, '0, 0);
    run("same_cyc", 0, 0, 0, 1'b1, 0, {3'd7, 3'd7, 3'd6, 4'b0100}, 0);
    run("busy_poke", 2, 0, 0, 1'b0, 0, '0, 5);
    run("reread", 2, 0, 0, 1'b0, 0, '0, 0);

    hold = 1'b1; start = 1'b1; last_idx = 3'd2;
    @(negedge clk);
    check(mk(1'b0, 1'b0, 1'b0, last_out, model_pc), "idle_hold", 1);
    hold = 1'b0; start = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      for (int unsigned j = 0; j < n; j++) prog_write($urandom_range(0, DEPTH-1), EW'($urandom));
      last = $urandom_range(0, DEPTH-1);
      ha = $urandom_range(1, 3*last + 4);
      hl = $urandom_range(0, 3);
      run("random", last, ha, hl, 1'b0, 0, '0, $urandom_range(0, 1) ? 2 : 0);
    end

    start = 1'b1; last_idx = 3'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
    last_out = '0; model_pc = '0;
    check(mk(1'b0, 1'b0, 1'b0, '0, 0), "mid_reset", 5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post_reset", 2, 0, 0, 1'b0, 0, '0, 0);

`ifdef REG_BANK_SEQ_SINGLE_STEP_EN
    prog_write(0, {3'd1, 3'd1, 3'd3, 4'b0011});
    prog_write(1, {3'd4, 3'd5, 3'd6, 4'b0110});
    step = 1'b0; start = 1'b1; last_idx = 3'd1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 3)
        check(mk(1'b1, 1'b0, 1'b1, mem[0], 0), "step_wb0", c);
      else if (c >= 4 && c <= 8)
        check(mk(1'b0, 1'b0, 1'b1, mem[0], 1), "step_pause", c);
      else if (c == 11)
        check(mk(1'b1, 1'b0, 1'b1, mem[1], 1), "step_wb1", c);
      else if (c == 12)
        check(mk(1'b0, 1'b1, 1'b1, mem[1], 1), "step_done", c);
      else if (c == 13)
        check(mk(1'b0, 1'b0, 1'b0, mem[1], 1), "step_idle", c);
      step = (c == 8);
      @(negedge clk);
    end
    step = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
